// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with a 2-bit saturating counter per entry,
// a Decode-stage prediction register, and branch/mispredict performance counters.

module bp_entry #(
  parameter int XLEN = 32,
  parameter int TAGW = 24
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            upd,
  input  logic            taken,
  input  logic [TAGW-1:0] tag_in,
  input  logic [XLEN-1:0] tgt_in,
  output logic            valid,
  output logic [TAGW-1:0] tag,
  output logic [XLEN-1:0] tgt,
  output logic [1:0]      ctr
);
  logic hit;
  assign hit = valid && (tag == tag_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      ctr   <= 2'b01;
    end else if (upd) begin
      if (hit) begin
        if (taken && ctr != 2'b11)      ctr <= ctr + 2'd1;
        else if (!taken && ctr != 2'b00) ctr <= ctr - 2'd1;
      end else if (taken) begin
        valid <= 1'b1;
        ctr   <= 2'b10;
      end
    end
  end

  // Tag and target carry no reset; they are qualified by valid.
  always_ff @(posedge clk) begin
    if (!reset && upd && taken) begin
      tgt <= tgt_in;
      if (!hit) tag <= tag_in;
    end
  end
endmodule

module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PCF,
  input  logic            StallD,
  input  logic            FlushD,
  output logic            BPF,
  output logic [XLEN-1:0] PredTargetF,
  output logic            BPD,
  output logic [XLEN-1:0] PredTargetD,
  input  logic            BranchE,
  input  logic            TakenE,
  input  logic            BPE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [31:0]     BranchCount,
  output logic [31:0]     MispredCount
);
  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;

  typedef struct packed {
    logic            en;
    logic            taken;
    logic [IDXW-1:0] idx;
    logic [TAGW-1:0] tag;
    logic [XLEN-1:0] tgt;
  } upd_t;

  upd_t upd;
  assign upd.en    = BranchE;
  assign upd.taken = TakenE;
  assign upd.idx   = PCE[IDXW+1:2];
  assign upd.tag   = PCE[XLEN-1:IDXW+2];
  assign upd.tgt   = PCTargetE;

  logic [ENTRIES-1:0]           ent_v;
  logic [ENTRIES-1:0][TAGW-1:0] ent_tag;
  logic [ENTRIES-1:0][XLEN-1:0] ent_tgt;
  logic [ENTRIES-1:0][1:0]      ent_ctr;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    bp_entry #(.XLEN(XLEN), .TAGW(TAGW)) u_ent (
      .clk    (clk),
      .reset  (reset),
      .upd    (upd.en && (upd.idx == IDXW'(i))),
      .taken  (upd.taken),
      .tag_in (upd.tag),
      .tgt_in (upd.tgt),
      .valid  (ent_v[i]),
      .tag    (ent_tag[i]),
      .tgt    (ent_tgt[i]),
      .ctr    (ent_ctr[i])
    );
  end

  // Lookup sees pre-update table contents; no same-cycle bypass from Execute.
  logic [IDXW-1:0] idxf;
  logic [TAGW-1:0] tagf;
  logic            hitf;
  assign idxf        = PCF[IDXW+1:2];
  assign tagf        = PCF[XLEN-1:IDXW+2];
  assign hitf        = ent_v[idxf] && (ent_tag[idxf] == tagf);
  assign BPF         = hitf && ent_ctr[idxf][1];
  assign PredTargetF = hitf ? ent_tgt[idxf] : '0;

  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      BPD         <= 1'b0;
      PredTargetD <= '0;
    end else if (!StallD) begin
      BPD         <= BPF;
      PredTargetD <= PredTargetF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      BranchCount  <= '0;
      MispredCount <= '0;
    end else if (BranchE) begin
      if (~&BranchCount) BranchCount <= BranchCount + 32'd1;
      if ((BPE != TakenE) && ~&MispredCount) MispredCount <= MispredCount + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a table model predicts F/D outputs and perf counters.

module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF, PredTargetF, PredTargetD, PCE, PCTargetE, BranchCount, MispredCount;
  logic        StallD, FlushD, BPF, BPD, BranchE, TakenE, BPE;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(64), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .PCF(PCF), .StallD(StallD), .FlushD(FlushD),
    .BPF(BPF), .PredTargetF(PredTargetF), .BPD(BPD), .PredTargetD(PredTargetD),
    .BranchE(BranchE), .TakenE(TakenE), .BPE(BPE), .PCE(PCE), .PCTargetE(PCTargetE),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", t, obs, exp);
    end
  endtask

  // Reference model
  logic        m_v   [64];
  logic [23:0] m_tag [64];
  logic [31:0] m_tgt [64];
  logic [1:0]  m_ctr [64];
  logic [31:0] m_br, m_mp;
  logic        md_bp;
  logic [31:0] md_tgt;

  typedef struct { logic bp; logic [31:0] tgt; logic [31:0] br; logic [31:0] mp; } exp_t;
  exp_t sb[$];

  task automatic mreset();
    for (int i = 0; i < 64; i++) begin m_v[i] = 1'b0; m_ctr[i] = 2'b01; end
    m_br = 0; m_mp = 0; md_bp = 1'b0; md_tgt = 0;
  endtask

  task automatic step(input logic [31:0] pc, input logic st, input logic fl, input logic br,
                      input logic tk, input logic bpe, input logic [31:0] pce,
                      input logic [31:0] tgt, input logic rs);
    int          i, j;
    logic        hit, ebp, hite;
    logic [31:0] etg;
    exp_t        e;
    PCF = pc; StallD = st; FlushD = fl; BranchE = br; TakenE = tk; BPE = bpe;
    PCE = pce; PCTargetE = tgt; reset = rs;
    #1;
    i   = int'(pc[7:2]);
    hit = m_v[i] && (m_tag[i] == pc[31:8]);
    ebp = hit && m_ctr[i][1];
    etg = hit ? m_tgt[i] : 32'h0;
    chk("bpf", {31'b0, BPF}, {31'b0, ebp});
    chk("tgtf", PredTargetF, etg);
    if (rs || fl) begin md_bp = 1'b0; md_tgt = 0; end
    else if (!st) begin md_bp = ebp; md_tgt = etg; end
    if (rs) mreset();
    else if (br) begin
      if (m_br != 32'hFFFF_FFFF) m_br++;
      if (bpe != tk && m_mp != 32'hFFFF_FFFF) m_mp++;
      j    = int'(pce[7:2]);
      hite = m_v[j] && (m_tag[j] == pce[31:8]);
      if (hite) begin
        if (tk && m_ctr[j] != 2'b11) m_ctr[j]++;
        if (!tk && m_ctr[j] != 2'b00) m_ctr[j]--;
        if (tk) m_tgt[j] = tgt;
      end else if (tk) begin
        m_v[j] = 1'b1; m_tag[j] = pce[31:8]; m_tgt[j] = tgt; m_ctr[j] = 2'b10;
      end
    end
    e.bp = md_bp; e.tgt = md_tgt; e.br = m_br; e.mp = m_mp;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("bpd", {31'b0, BPD}, {31'b0, e.bp});
    chk("tgtd", PredTargetD, e.tgt);
    chk("brcnt", BranchCount, e.br);
    chk("mpcnt", MispredCount, e.mp);
    reset = 1'b0; BranchE = 1'b0; StallD = 1'b0; FlushD = 1'b0;
  endtask

  // Plain lookup with no branch, then compare against literal expectations.
  task automatic peek(input string t, input logic [31:0] pc, input logic eb, input logic [31:0] et);
    PCF = pc; #1;
    chk({t, "_bp"}, {31'b0, BPF}, {31'b0, eb});
    chk({t, "_tg"}, PredTargetF, et);
  endtask

  task automatic br(input logic [31:0] pce, input logic tk, input logic bpe, input logic [31:0] tgt);
    step(32'h0, 0, 0, 1, tk, bpe, pce, tgt, 0);
  endtask

  logic [31:0] pcs [8];

  initial begin
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h200; pcs[3] = 32'h108;
    pcs[4] = 32'h500; pcs[5] = 32'h1FC; pcs[6] = 32'h2FC; pcs[7] = 32'h3C0;
    {StallD, FlushD, BranchE, TakenE, BPE} = '0;
    PCF = 0; PCE = 0; PCTargetE = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    mreset();

    // Reset state
    peek("rst", 32'h100, 1'b0, 32'h0);
    chk("rst_bpd", {31'b0, BPD}, 32'h0);
    chk("rst_br", BranchCount, 32'h0);
    chk("rst_mp", MispredCount, 32'h0);
    step(32'h100, 0, 0, 0, 0, 0, 0, 0, 0);

    // Allocate on taken miss
    br(32'h100, 1, 0, 32'h80);
    peek("alloc", 32'h100, 1'b1, 32'h80);
    chk("alloc_mp", MispredCount, 32'd1);
    step(32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("alloc_bpd", {31'b0, BPD}, 32'h1);
    chk("alloc_tgtd", PredTargetD, 32'h80);

    // Counter saturation and decay
    repeat (3) br(32'h100, 1, 1, 32'h80);
    br(32'h100, 0, 1, 32'h80);
    peek("ctr10", 32'h100, 1'b1, 32'h80);
    br(32'h100, 0, 1, 32'h80);
    peek("ctr01", 32'h100, 1'b0, 32'h80);

    // Aliasing replaces the entry
    br(32'h100, 1, 0, 32'h80);
    br(32'h200, 1, 0, 32'h240);
    peek("alias_old", 32'h100, 1'b0, 32'h0);
    peek("alias_new", 32'h203, 1'b1, 32'h240);

    // Stall holds D, flush beats stall
    step(32'h200, 0, 0, 0, 0, 0, 0, 0, 0);
    step(32'h100, 1, 0, 0, 0, 0, 0, 0, 0);
    step(32'h500, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_bpd", {31'b0, BPD}, 32'h1);
    chk("stall_tgtd", PredTargetD, 32'h240);
    step(32'h200, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("flush_bpd", {31'b0, BPD}, 32'h0);

    // Same-cycle allocate at the looked-up index: no bypass
    step(32'h104, 0, 0, 1, 1, 0, 32'h104, 32'h444, 0);
    peek("nobyp", 32'h104, 1'b1, 32'h444);

    // Reset overrides a same-cycle branch
    step(32'h108, 0, 0, 1, 1, 0, 32'h108, 32'h888, 1);
    peek("rstbr", 32'h108, 1'b0, 32'h0);
    chk("rstbr_br", BranchCount, 32'h0);
    chk("rstbr_mp", MispredCount, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      logic [31:0] p, q;
      p = pcs[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      q = pcs[$urandom_range(0, 7)];
      step(p, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, q,
           $urandom & 32'hFFFF_FFFC, $urandom_range(0, 63) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
